// File: rtl/btree_up_arbiter.sv
// btree_up_arbiter: two-input round-robin merge of child packets into a 2-entry FIFO
// toward the parent port. Grant statistics are built only when BTREE_ARB_STATS_EN is defined.
module btree_up_arbiter #(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 2,
   parameter int unsigned TotalWidth = DataWidth + AddrWidth
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [TotalWidth-1:0] i_l_data,
   input  logic                  i_l_valid,
   output logic                  o_l_ready,
   input  logic [TotalWidth-1:0] i_r_data,
   input  logic                  i_r_valid,
   output logic                  o_r_ready,
   output logic [TotalWidth-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [15:0]           o_grant_cnt_l,
   output logic [15:0]           o_grant_cnt_r
);

   logic [TotalWidth-1:0] mem_q [2];
   logic [1:0]            cnt_q, cnt_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  prio_q, prio_d;
   logic                  space, l_rdy, r_rdy;
   logic                  push_l, push_r, push, pop;
   logic [TotalWidth-1:0] wdata;

   // space depends only on registered occupancy, so i_ready never reaches the child readies.
   always_comb begin
      space    = (cnt_q != 2'd2);
      l_rdy    = rst_n && space && (!prio_q || !i_r_valid);
      r_rdy    = rst_n && space && (prio_q || !i_l_valid);
      push_l   = i_l_valid && l_rdy;
      push_r   = i_r_valid && r_rdy && !push_l;
      push     = push_l || push_r;
      pop      = (cnt_q != 2'd0) && i_ready;
      wdata    = push_l ? i_l_data : i_r_data;
      cnt_d    = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 2'd1;
      end
      wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
      prio_d   = prio_q;
      if (push_l) begin
         prio_d = 1'b1;
      end else if (push_r) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         prio_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         prio_q   <= prio_d;
         if (push) begin
            mem_q[wr_ptr_q] <= wdata;
         end
      end
   end

   assign o_l_ready = l_rdy;
   assign o_r_ready = r_rdy;
   assign o_valid   = (cnt_q != 2'd0);
   assign o_data    = mem_q[rd_ptr_q];

`ifdef BTREE_ARB_STATS_EN
   logic [15:0] gcnt_l_q, gcnt_r_q;

   // Saturating grant counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt_l_q <= 16'h0000;
         gcnt_r_q <= 16'h0000;
      end else begin
         if (push_l && (gcnt_l_q != 16'hFFFF)) begin
            gcnt_l_q <= gcnt_l_q + 16'd1;
         end
         if (push_r && (gcnt_r_q != 16'hFFFF)) begin
            gcnt_r_q <= gcnt_r_q + 16'd1;
         end
      end
   end

   assign o_grant_cnt_l = gcnt_l_q;
   assign o_grant_cnt_r = gcnt_r_q;
`else
   assign o_grant_cnt_l = 16'h0000;
   assign o_grant_cnt_r = 16'h0000;
`endif

endmodule

// File: tb/tb_btree_up_arbiter.sv
// Directed self-checking bench for btree_up_arbiter: reset, single source, contention,
// backpressure, steady push/pop, mid-traffic reset and grant statistics.
module tb_btree_up_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [33:0] i_l_data, i_r_data, o_data;
   logic        i_l_valid, i_r_valid, i_ready;
   logic        o_l_ready, o_r_ready, o_valid;
   logic [15:0] o_grant_cnt_l, o_grant_cnt_r;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   btree_up_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_l_data      (i_l_data),
      .i_l_valid     (i_l_valid),
      .o_l_ready     (o_l_ready),
      .i_r_data      (i_r_data),
      .i_r_valid     (i_r_valid),
      .o_r_ready     (o_r_ready),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_grant_cnt_l (o_grant_cnt_l),
      .o_grant_cnt_r (o_grant_cnt_r)
   );

   function automatic logic [33:0] lpkt(input int i);
      return {2'd1, 32'hA000_0000 + i};
   endfunction

   function automatic logic [33:0] rpkt(input int i);
      return {2'd2, 32'hB000_0000 + i};
   endfunction

   function automatic logic [33:0] ppkt(input int i);
      return {2'd3, 32'h5000_0000 + i};
   endfunction

   task automatic drv(input logic lv, input logic [33:0] ld, input logic rv,
                      input logic [33:0] rd, input logic rdy);
      i_l_valid = lv;
      i_l_data  = ld;
      i_r_valid = rv;
      i_r_data  = rd;
      i_ready   = rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drv(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drv(1'b0, '0, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_checks++; if (o_l_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lrdy_held: got %b want 0", o_l_ready); end
      n_checks++; if (o_r_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rrdy_held: got %b want 0", o_r_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      n_checks++; if (o_data !== 34'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", o_data); end
      n_checks++; if (o_l_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lrdy: got %b want 1", o_l_ready); end
      n_checks++; if (o_r_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rrdy: got %b want 1", o_r_ready); end
      n_checks++; if (o_grant_cnt_l !== 16'h0) begin n_fail++; $display("FAIL rst_cnt_l: got %h want 0", o_grant_cnt_l); end
      n_checks++; if (o_grant_cnt_r !== 16'h0) begin n_fail++; $display("FAIL rst_cnt_r: got %h want 0", o_grant_cnt_r); end
   endtask

   task automatic test_single_source();
      logic [33:0] p [4];
      p[0] = {2'd0, 32'h1};
      p[1] = {2'd1, 32'h2};
      p[2] = {2'd2, 32'h3};
      p[3] = {2'd3, 32'h4};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) drv(1'b1, p[k], 1'b0, '0, 1'b1);
         else drv(1'b0, '0, 1'b0, '0, 1'b1);
         #1;
         if (k < 4) begin
            n_checks++; if (o_l_ready !== 1'b1) begin n_fail++; $display("FAIL single_lrdy[%0d]: got %b want 1", k, o_l_ready); end
         end
         n_checks++;
         if (o_valid !== (k >= 1 && k <= 4)) begin
            n_fail++; $display("FAIL single_valid[%0d]: got %b want %b", k, o_valid, (k >= 1 && k <= 4));
         end
         if (k >= 1 && k <= 4) begin
            n_checks++; if (o_data !== p[k-1]) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", k, o_data, p[k-1]); end
         end
      end
   endtask

   task automatic test_contention();
      int li = 0;
      int ri = 0;
      logic [33:0] exp_d;
      do_reset();
      for (int cyc = 0; cyc <= 16; cyc++) begin
         if (cyc > 0) @(negedge clk);
         drv(li < 8, lpkt(li), ri < 8, rpkt(ri), 1'b1);
         #1;
         if (cyc < 16) begin
            n_checks++; if (o_l_ready !== (cyc % 2 == 0)) begin n_fail++; $display("FAIL cont_lrdy[%0d]: got %b want %b", cyc, o_l_ready, (cyc % 2 == 0)); end
            n_checks++; if (o_r_ready !== (cyc % 2 == 1)) begin n_fail++; $display("FAIL cont_rrdy[%0d]: got %b want %b", cyc, o_r_ready, (cyc % 2 == 1)); end
         end
         if (cyc > 0) begin
            exp_d = ((cyc - 1) % 2 == 0) ? lpkt((cyc - 1) / 2) : rpkt((cyc - 1) / 2);
            n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid[%0d]: got %b want 1", cyc, o_valid); end
            n_checks++; if (o_data !== exp_d) begin n_fail++; $display("FAIL cont_data[%0d]: got %h want %h", cyc, o_data, exp_d); end
         end
         if (i_l_valid && o_l_ready) li++;
         if (i_r_valid && o_r_ready) ri++;
      end
      @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain: got %b want 0", o_valid); end
`ifdef BTREE_ARB_STATS_EN
      n_checks++; if (o_grant_cnt_l !== 16'd8) begin n_fail++; $display("FAIL cont_cnt_l: got %0d want 8", o_grant_cnt_l); end
      n_checks++; if (o_grant_cnt_r !== 16'd8) begin n_fail++; $display("FAIL cont_cnt_r: got %0d want 8", o_grant_cnt_r); end
`endif
   endtask

   task automatic test_backpressure();
      logic [6:0] el = 7'b0100001;
      logic [6:0] er = 7'b1000010;
      logic [6:0] ev = 7'b1111110;
      logic [33:0] exp_d;
      int li = 0;
      int ri = 0;
      do_reset();
      for (int cyc = 0; cyc < 7; cyc++) begin
         if (cyc > 0) @(negedge clk);
         drv(1'b1, lpkt(li), 1'b1, rpkt(ri), cyc >= 4);
         #1;
         exp_d = (cyc < 5) ? lpkt(0) : (cyc == 5) ? rpkt(0) : lpkt(1);
         n_checks++; if (o_l_ready !== el[cyc]) begin n_fail++; $display("FAIL bp_lrdy[%0d]: got %b want %b", cyc, o_l_ready, el[cyc]); end
         n_checks++; if (o_r_ready !== er[cyc]) begin n_fail++; $display("FAIL bp_rrdy[%0d]: got %b want %b", cyc, o_r_ready, er[cyc]); end
         n_checks++; if (o_valid !== ev[cyc]) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want %b", cyc, o_valid, ev[cyc]); end
         if (cyc > 0) begin
            n_checks++; if (o_data !== exp_d) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", cyc, o_data, exp_d); end
         end
         if (i_l_valid && o_l_ready) li++;
         if (i_r_valid && o_r_ready) ri++;
      end
      @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_data !== rpkt(1)) begin n_fail++; $display("FAIL bp_tail_data: got %h want %h", o_data, rpkt(1)); end
      @(negedge clk);
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", o_valid); end
   endtask

   task automatic test_push_pop();
      do_reset();
      drv(1'b1, ppkt(0), 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL pp_first_valid: got %b want 0", o_valid); end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         drv(1'b1, ppkt(k), 1'b0, '0, 1'b1);
         #1;
         n_checks++; if (o_l_ready !== 1'b1) begin n_fail++; $display("FAIL pp_lrdy[%0d]: got %b want 1", k, o_l_ready); end
         n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL pp_valid[%0d]: got %b want 1", k, o_valid); end
         n_checks++; if (o_data !== ppkt(k - 1)) begin n_fail++; $display("FAIL pp_data[%0d]: got %h want %h", k, o_data, ppkt(k - 1)); end
      end
      @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_data !== ppkt(20)) begin n_fail++; $display("FAIL pp_last: got %h want %h", o_data, ppkt(20)); end
      @(negedge clk);
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b want 0", o_valid); end
   endtask

   task automatic test_reset_mid_traffic();
      do_reset();
      drv(1'b1, lpkt(40), 1'b1, rpkt(40), 1'b0);
      @(negedge clk);
      drv(1'b1, lpkt(41), 1'b1, rpkt(40), 1'b0);
      @(negedge clk);
      #1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full_valid: got %b want 1", o_valid); end
      n_checks++; if ({o_l_ready, o_r_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_full_rdy: got %b want 00", {o_l_ready, o_r_ready}); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", o_valid); end
      n_checks++; if (o_data !== 34'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", o_data); end
      n_checks++; if ({o_l_ready, o_r_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rdy: got %b want 00", {o_l_ready, o_r_ready}); end
      @(negedge clk);
      rst_n = 1'b1;
      drv(1'b1, lpkt(50), 1'b1, rpkt(50), 1'b1);
      #1;
      n_checks++; if ({o_l_ready, o_r_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_post_rdy: got %b want 10", {o_l_ready, o_r_ready}); end
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", o_valid); end
      @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_data !== lpkt(50)) begin n_fail++; $display("FAIL mid_post_data: got %h want %h", o_data, lpkt(50)); end
      @(negedge clk);
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_empty: got %b want 0", o_valid); end
   endtask

   task automatic test_stats();
      do_reset();
`ifdef BTREE_ARB_STATS_EN
      drv(1'b1, lpkt(60), 1'b0, '0, 1'b1);
      repeat (65540) @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_grant_cnt_l !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat_l: got %h want FFFF", o_grant_cnt_l); end
      n_checks++; if (o_grant_cnt_r !== 16'h0000) begin n_fail++; $display("FAIL stats_sat_r: got %h want 0000", o_grant_cnt_r); end
`else
      drv(1'b1, lpkt(60), 1'b1, rpkt(60), 1'b1);
      repeat (6) @(negedge clk);
      drv(1'b0, '0, 1'b0, '0, 1'b1);
      #1;
      n_checks++; if (o_grant_cnt_l !== 16'h0000) begin n_fail++; $display("FAIL stats_off_l: got %h want 0000", o_grant_cnt_l); end
      n_checks++; if (o_grant_cnt_r !== 16'h0000) begin n_fail++; $display("FAIL stats_off_r: got %h want 0000", o_grant_cnt_r); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_contention();
      test_backpressure();
      test_push_pop();
      test_reset_mid_traffic();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
